// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM SD sector sequencer.
package bk_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} bk_state_t;

  localparam int SECTOR_LOG2 = 9;
  localparam int LBA_W       = 32;

  // Edge detector lane assignment.
  localparam int NUM_EDGES = 4;
  localparam int E_LOAD    = 0;
  localparam int E_SAVE    = 1;
  localparam int E_DL      = 2;
  localparam int E_OSD     = 3;

  typedef struct packed {
    logic go;
    logic load;
  } bk_req_t;

  // Highest-priority trigger wins; direction follows it.
  function automatic bk_req_t bk_arbitrate(input logic autoload, input logic load,
                                           input logic save, input logic autosave);
    bk_req_t r;
    r.go   = autoload | load | save | autosave;
    r.load = autoload | load;
    return r;
  endfunction
endpackage

// File: rtl/edge_det.sv
// Registered rise/fall detector: compares the live input against its value
// from the previous clk_sys edge.
module edge_det (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) q <= 1'b0;
    else          q <= d;

  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/bk_sd_sequencer.sv
// Backup-RAM sector sequencer: autoload after ROM download, load/save on OSD
// request, 512-byte sectors to hps_io. Optional BK_AUTOSAVE_EN: save on OSD close.
module bk_sd_sequencer
  import bk_pkg::*;
#(
  parameter int LBA_BITS = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic              img_size_nz,
  input  logic [23:0]       ram_mask,
  input  logic              bk_load_req,
  input  logic              bk_save_req,
  input  logic              bsram_wr,
  input  logic              osd_status,
  input  logic              sd_ack,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              bk_dirty
);
  bk_state_t             state;
  logic [LBA_BITS-1:0]   lba;
  logic                  is_load;
  logic [NUM_EDGES-1:0]  ed_in, rise_v, fall_v;
  logic                  trig_asave, last;
  bk_req_t               req;

`ifdef BK_AUTOSAVE_EN
  assign ed_in      = {osd_status, ioctl_download, bk_save_req & bk_ena, bk_load_req & bk_ena};
  assign trig_asave = fall_v[E_OSD] & bk_ena & bk_dirty;
  wire unused_edges = &{1'b0, rise_v[E_OSD], rise_v[E_DL], fall_v[E_LOAD], fall_v[E_SAVE]};
`else
  assign ed_in      = {1'b0, ioctl_download, bk_save_req & bk_ena, bk_load_req & bk_ena};
  assign trig_asave = 1'b0;
  wire unused_edges = &{1'b0, osd_status, rise_v[E_OSD], fall_v[E_OSD], rise_v[E_DL],
                        fall_v[E_LOAD], fall_v[E_SAVE]};
`endif

  for (genvar g = 0; g < NUM_EDGES; g++) begin : g_edge
    edge_det u_ed (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (ed_in[g]),
      .rise    (rise_v[g]),
      .fall    (fall_v[g])
    );
  end

  assign req = bk_arbitrate(fall_v[E_DL] & bk_ena, rise_v[E_LOAD], rise_v[E_SAVE], trig_asave);

  // Masks below one sector give ram_mask[23:9] == 0, so LBA 0 is also the last.
  assign last    = LBA_W'(lba) >= LBA_W'(ram_mask[23:SECTOR_LOG2]);
  assign sd_lba  = LBA_W'(lba);
  assign bk_busy = (state != IDLE);

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n)                  bk_ena <= 1'b0;
    else if (rise_v[E_DL])         bk_ena <= 1'b0;
    else if (ioctl_download & img_mounted & img_size_nz & ~img_readonly)
                                   bk_ena <= |ram_mask;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lba        <= '0;
      is_load    <= 1'b0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_loading <= 1'b0;
      bk_dirty   <= 1'b0;
    end else if (rise_v[E_DL]) begin
      state      <= IDLE;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_loading <= 1'b0;
      bk_dirty   <= 1'b0;
    end else begin
      if (bsram_wr && !bk_loading) bk_dirty <= 1'b1;
      case (state)
        IDLE: if (req.go) begin
          lba        <= '0;
          is_load    <= req.load;
          bk_loading <= req.load;
          sd_rd      <= req.load;
          sd_wr      <= ~req.load;
          state      <= REQ;
        end
        REQ: if (sd_ack) begin
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (!sd_ack) begin
          // Done clears dirty even if a write lands in the same cycle.
          if (last) begin
            bk_loading <= 1'b0;
            bk_dirty   <= 1'b0;
            state      <= IDLE;
          end else begin
            lba   <= lba + LBA_BITS'(1);
            sd_rd <= is_load;
            sd_wr <= ~is_load;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Self-checking bench for bk_sd_sequencer: vector table, hand sequences and
// randomized load/save runs against a sector-count reference model.
module tb_bk_sd_sequencer;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, img_mounted, img_readonly, img_size_nz;
  logic [23:0] ram_mask;
  logic        bk_load_req, bk_save_req, bsram_wr, osd_status, sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  bk_sd_sequencer #(.LBA_BITS(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
    .ram_mask(ram_mask), .bk_load_req(bk_load_req), .bk_save_req(bk_save_req),
    .bsram_wr(bsram_wr), .osd_status(osd_status), .sd_ack(sd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_loading(bk_loading),
    .bk_busy(bk_busy), .bk_dirty(bk_dirty)
  );

  typedef struct {bit rd; bit wr; int lba; bit ld;} rec_t;
  rec_t obs[$];

  typedef struct {
    logic [23:0] mask;
    bit mnt, ro, nz;
    bit ena;
    int n_auto, n_save;
  } vec_t;
  vec_t tbl[8];

  // hps_io stand-in: logs each request, acks after random latency/width.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset_n && (sd_rd || sd_wr) && !sd_ack) begin
        obs.push_back('{sd_rd, sd_wr, int'(sd_lba), bk_loading});
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: sim still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Model: a valid writable image with save RAM moves ram_mask/512 + 1 sectors.
  function automatic int model_sectors(input logic [23:0] m, input bit mnt, input bit ro,
                                       input bit nz);
    if (!(mnt && nz && !ro && m != 0)) return 0;
    return (int'(m) >> 9) + 1;
  endfunction

  task automatic wait_idle(input string nm);
    @(negedge clk_sys);
    for (int i = 0; i < 4000 && bk_busy; i++) @(negedge clk_sys);
    chk({nm, "_idle"}, bk_busy, 0);
  endtask

  task automatic check_xfers(input string nm, input int n, input bit rd);
    chk({nm, "_count"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) begin
      chk({nm, "_lba"}, obs[i].lba, i);
      chk({nm, "_dir"}, {obs[i].rd, obs[i].wr, obs[i].ld}, rd ? 3'b101 : 3'b010);
    end
  endtask

  task automatic download(input logic [23:0] m, input bit mnt, input bit ro, input bit nz,
                          input bit wait_done);
    @(negedge clk_sys);
    ram_mask = m;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    img_mounted = mnt; img_readonly = ro; img_size_nz = nz;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    repeat (2) @(negedge clk_sys);
    obs.delete();
    ioctl_download = 1'b0;
    if (wait_done) wait_idle("dl");
  endtask

  task automatic pulse_req(input bit load);
    @(negedge clk_sys);
    obs.delete();
    if (load) bk_load_req = 1'b1; else bk_save_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    bk_load_req = 1'b0; bk_save_req = 1'b0;
  endtask

  task automatic pulse_wr();
    @(negedge clk_sys); bsram_wr = 1'b1;
    @(negedge clk_sys); bsram_wr = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 1000 && obs.size() < n; i++) @(negedge clk_sys);
    chk("obs_reach", int'(obs.size() >= n), 1);
  endtask

  initial begin
    tbl[0] = '{24'h001FFF, 1, 0, 1, 1, 16, 16};
    tbl[1] = '{24'h000000, 1, 0, 1, 0, 0, 0};
    tbl[2] = '{24'h0007FF, 1, 1, 1, 0, 0, 0};
    tbl[3] = '{24'h0007FF, 1, 0, 1, 1, 4, 4};
    tbl[4] = '{24'h0001FF, 1, 0, 1, 1, 1, 1};
    tbl[5] = '{24'h0007FF, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{24'h0007FF, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{24'h00FFFF, 1, 0, 1, 1, 128, 128};

    reset_n = 1'b0;
    ioctl_download = 0; img_mounted = 0; img_readonly = 0; img_size_nz = 0;
    ram_mask = '0; bk_load_req = 0; bk_save_req = 0; bsram_wr = 0; osd_status = 0;
    repeat (3) @(negedge clk_sys);
    chk("rst_flags", {sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_dirty}, 0);
    chk("rst_lba", sd_lba, 0);
    reset_n = 1'b1;

    foreach (tbl[v]) begin
      download(tbl[v].mask, tbl[v].mnt, tbl[v].ro, tbl[v].nz, 1);
      chk("tbl_ena", bk_ena, tbl[v].ena);
      check_xfers("tbl_auto", tbl[v].n_auto, 1);
      chk("tbl_auto_flags", {bk_loading, bk_dirty}, 0);
      pulse_wr();
      chk("tbl_dirty_set", bk_dirty, 1);
      pulse_req(0);
      wait_idle("tbl_save");
      check_xfers("tbl_save", tbl[v].n_save, 0);
      chk("tbl_save_flags", {bk_loading, bk_dirty}, {1'b0, tbl[v].n_save == 0});
    end

    // Writes during a load are ignored; writes during a save are wiped at done.
    download(24'h001FFF, 1, 0, 1, 0);
    wait_obs(2);
    chk("ld_loading", bk_loading, 1);
    pulse_wr();
    wait_idle("ld_wr");
    chk("ld_wr_dirty", bk_dirty, 0);
    pulse_req(0);
    wait_obs(2);
    pulse_wr();
    wait_idle("sv_wr");
    check_xfers("sv_wr", 16, 0);
    chk("sv_wr_dirty", bk_dirty, 0);
    pulse_wr();
    chk("post_wr_dirty", bk_dirty, 1);

    // Abort: download rises while sector 2 of an autoload is in flight.
    download(24'h001FFF, 1, 0, 1, 0);
    wait_obs(3);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("abort_flags", {bk_busy, sd_rd, bk_loading, bk_ena, bk_dirty}, 0);
    repeat (4) @(negedge clk_sys);
    obs.delete();
    ioctl_download = 1'b0;
    repeat (12) @(negedge clk_sys);
    chk("abort_no_reload", obs.size() + int'(bk_busy), 0);

    // OSD close with dirty save RAM.
    download(24'h0007FF, 1, 0, 1, 1);
    pulse_wr();
    @(negedge clk_sys); osd_status = 1'b1;
    repeat (2) @(negedge clk_sys);
    obs.delete();
    osd_status = 1'b0;
    wait_idle("osd");
    repeat (2) @(negedge clk_sys);
`ifdef BK_AUTOSAVE_EN
    check_xfers("autosave", 4, 0);
    chk("autosave_dirty", bk_dirty, 0);
`else
    check_xfers("no_autosave", 0, 0);
    chk("no_autosave_dirty", bk_dirty, 1);
`endif

    for (int it = 0; it < 20; it++) begin
      logic [23:0] m;
      bit ro, ld;
      int k, n;
      k  = $urandom_range(0, 6);
      m  = (k == 0) ? 24'h0 : (k == 6) ? 24'($urandom_range(0, 16383)) : 24'((1 << (k + 7)) - 1);
      ro = ($urandom_range(0, 3) == 0);
      ld = $urandom_range(0, 1);
      n  = model_sectors(m, 1, ro, 1);
      download(m, 1, ro, 1, 1);
      chk("rnd_ena", bk_ena, int'(n != 0));
      check_xfers("rnd_auto", n, 1);
      pulse_req(ld);
      wait_idle("rnd_op");
      check_xfers(ld ? "rnd_load" : "rnd_save", n, ld);
      chk("rnd_loading", bk_loading, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
